ps2_kbd_ctrl: RTL and testbench

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

---
 rtl/ps2_kbd_pkg.sv | 16 +
 rtl/ps2_kbd_ctrl.sv | 142 ++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared FSM state encoding and special scan-code bytes for the PS/2 keyboard controller.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        DECODE,
        EMIT
    } state_e;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_ERR0 = 8'h00;
    localparam logic [7:0] SC_ERR1 = 8'hFF;

endpackage

// File: rtl/ps2_kbd_ctrl.sv
// Turns the raw scan-byte stream from the PS/2 receiver FIFO into make/break key events
// with E0/F0 prefix folding, optional typematic-repeat suppression and a sticky error flag.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter bit FILTER_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    input  logic       kbd_overflow,
    output logic       kbd_nextdata_n,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       err,
    input  logic       err_clr
);

    state_e     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;
    logic [8:0] held_key_q, held_key_d;
    logic       held_vld_q, held_vld_d;
    logic [7:0] evt_code_q, evt_code_d;
    logic       evt_ext_q, evt_ext_d;
    logic       evt_brk_q, evt_brk_d;
    logic       err_q, err_d;
    logic       held_match;

    assign held_match = held_vld_q && (held_key_q == {ext_pend_q, byte_q});

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        held_key_d = held_key_q;
        held_vld_d = held_vld_q;
        evt_code_d = evt_code_q;
        evt_ext_d  = evt_ext_q;
        evt_brk_d  = evt_brk_q;
        err_d      = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (kbd_ready) begin
                    byte_d  = kbd_data;
                    state_d = POP;
                end
            end
            POP: begin
                state_d = DECODE;
            end
            DECODE: begin
                state_d = IDLE;
                if (byte_q == SC_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (byte_q == SC_BRK) begin
                    brk_pend_d = 1'b1;
                end else if (byte_q == SC_ERR0 || byte_q == SC_ERR1) begin
                    err_d      = 1'b1;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end else begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    // Repeat makes of the held key are dropped here, never reaching EMIT.
                    if (brk_pend_q || !(FILTER_REPEAT && held_match)) begin
                        state_d    = EMIT;
                        evt_code_d = byte_q;
                        evt_ext_d  = ext_pend_q;
                        evt_brk_d  = brk_pend_q;
                    end
                    if (brk_pend_q) begin
                        if (held_match) begin
                            held_vld_d = 1'b0;
                        end
                    end else begin
                        held_key_d = {ext_pend_q, byte_q};
                        held_vld_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (evt_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Overflow is applied last so a set always beats a same-cycle clear.
        if (kbd_overflow) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            held_key_q <= '0;
            held_vld_q <= 1'b0;
            evt_code_q <= '0;
            evt_ext_q  <= 1'b0;
            evt_brk_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            held_key_q <= held_key_d;
            held_vld_q <= held_vld_d;
            evt_code_q <= evt_code_d;
            evt_ext_q  <= evt_ext_d;
            evt_brk_q  <= evt_brk_d;
            err_q      <= err_d;
        end
    end

    assign kbd_nextdata_n = (state_q != POP);
    assign evt_valid      = (state_q == EMIT);
    assign evt_code       = evt_code_q;
    assign evt_ext        = evt_ext_q;
    assign evt_break      = evt_brk_q;
    assign err            = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: a byte-array FIFO model feeds the controller and an
// event log records every accepted {ext, break, code} triple for comparison.
module tb_ps2_kbd_ctrl;

    logic       clk;
    logic       clrn;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_overflow;
    logic       kbd_nextdata_n;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       err;
    logic       err_clr;

    logic [7:0] src [0:127];
    logic [6:0] src_wr;
    logic [6:0] src_rd;
    int         bad_pops;
    logic [9:0] evq [$];

    int tests;
    int fails;

    ps2_kbd_ctrl #(.FILTER_REPEAT(1'b1)) dut (
        .clk            (clk),
        .clrn           (clrn),
        .kbd_data       (kbd_data),
        .kbd_ready      (kbd_ready),
        .kbd_overflow   (kbd_overflow),
        .kbd_nextdata_n (kbd_nextdata_n),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_code       (evt_code),
        .evt_ext        (evt_ext),
        .evt_break      (evt_break),
        .err            (err),
        .err_clr        (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign kbd_ready = (src_rd != src_wr);
    assign kbd_data  = src[src_rd];

    // Receiver model and event log, both sampled on the falling edge.
    initial begin
        src_rd   = '0;
        bad_pops = 0;
    end
    always @(negedge clk) begin
        if (clrn && !kbd_nextdata_n) begin
            if (src_rd == src_wr) bad_pops = bad_pops + 1;
            else src_rd = src_rd + 7'd1;
        end
        if (clrn && evt_valid && evt_ready) begin
            evq.push_back({evt_ext, evt_break, evt_code});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        src[src_wr] = b;
        src_wr      = src_wr + 7'd1;
    endtask

    logic [9:0] ev;
    int         base;
    logic [6:0] pop_mark;
    logic       hold_bad;
    logic       seen;

    initial begin
        tests        = 0;
        fails        = 0;
        src_wr       = '0;
        clrn         = 1'b0;
        kbd_overflow = 1'b0;
        evt_ready    = 1'b1;
        err_clr      = 1'b0;
        for (int i = 0; i < 128; i++) src[i] = 8'h00;
        cyc(2);

        chk("rst_valid",   {31'd0, evt_valid},      32'd0);
        chk("rst_pop_n",   {31'd0, kbd_nextdata_n}, 32'd1);
        chk("rst_code",    {24'd0, evt_code},       32'd0);
        chk("rst_ext",     {31'd0, evt_ext},        32'd0);
        chk("rst_break",   {31'd0, evt_break},      32'd0);
        chk("rst_err",     {31'd0, err},            32'd0);
        clrn = 1'b1;
        cyc(2);

        // Make then break of 1C
        base = evq.size();
        push(8'h1C); push(8'hF0); push(8'h1C);
        cyc(30);
        chk("t1_count", evq.size() - base, 32'd2);
        ev = (evq.size() > base) ? evq[base] : 10'h3FF;
        chk("t1_make", {22'd0, ev}, {22'd0, 10'h01C});
        ev = (evq.size() > base + 1) ? evq[base + 1] : 10'h3FF;
        chk("t1_break", {22'd0, ev}, {22'd0, 10'h11C});
        chk("t1_pops", {25'd0, src_rd}, 32'd3);

        // Extended keys, prefix order, prefix surviving an idle gap
        base = evq.size();
        push(8'hE0); push(8'h75);
        push(8'hE0); push(8'hF0); push(8'h75);
        push(8'hF0); push(8'hE0); push(8'h75);
        push(8'hE0);
        cyc(60);
        push(8'h6B);
        cyc(20);
        chk("t2_count", evq.size() - base, 32'd4);
        ev = (evq.size() > base) ? evq[base] : 10'h3FF;
        chk("t2_ext_make", {22'd0, ev}, {22'd0, 10'h275});
        ev = (evq.size() > base + 1) ? evq[base + 1] : 10'h3FF;
        chk("t2_e0f0_brk", {22'd0, ev}, {22'd0, 10'h375});
        ev = (evq.size() > base + 2) ? evq[base + 2] : 10'h3FF;
        chk("t2_f0e0_brk", {22'd0, ev}, {22'd0, 10'h375});
        ev = (evq.size() > base + 3) ? evq[base + 3] : 10'h3FF;
        chk("t2_gap_ext", {22'd0, ev}, {22'd0, 10'h26B});
        chk("t2_pops", {25'd0, src_rd}, 32'd13);

        // Typematic repeat filtering (held key is now {1,6B}, so 1C is fresh)
        base = evq.size();
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        cyc(40);
        chk("t3_count", evq.size() - base, 32'd2);
        ev = (evq.size() > base) ? evq[base] : 10'h3FF;
        chk("t3_make", {22'd0, ev}, {22'd0, 10'h01C});
        ev = (evq.size() > base + 1) ? evq[base + 1] : 10'h3FF;
        chk("t3_break", {22'd0, ev}, {22'd0, 10'h11C});
        chk("t3_pops", {25'd0, src_rd}, 32'd18);

        // Backpressure: event held, FIFO not popped while stalled
        base      = evq.size();
        evt_ready = 1'b0;
        push(8'h1C); push(8'h2A);
        cyc(4);
        pop_mark = src_rd;
        hold_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (!evt_valid || evt_code !== 8'h1C || evt_ext !== 1'b0 || evt_break !== 1'b0
                || kbd_nextdata_n !== 1'b1)
                hold_bad = 1'b1;
        end
        chk("t4_valid", {31'd0, evt_valid}, 32'd1);
        chk("t4_stable", {31'd0, hold_bad}, 32'd0);
        chk("t4_no_pop", {25'd0, src_rd}, {25'd0, pop_mark});
        chk("t4_fifo_ne", {31'd0, kbd_ready}, 32'd1);
        evt_ready = 1'b1;
        cyc(20);
        chk("t4_count", evq.size() - base, 32'd2);
        ev = (evq.size() > base) ? evq[base] : 10'h3FF;
        chk("t4_ev0", {22'd0, ev}, {22'd0, 10'h01C});
        ev = (evq.size() > base + 1) ? evq[base + 1] : 10'h3FF;
        chk("t4_ev1", {22'd0, ev}, {22'd0, 10'h02A});

        // Error byte clears the prefix; err_clr; set beats clear
        base = evq.size();
        push(8'hE0); push(8'hFF);
        cyc(12);
        chk("t5_err", {31'd0, err}, 32'd1);
        chk("t5_no_evt", evq.size() - base, 32'd0);
        push(8'h1C);
        cyc(10);
        ev = (evq.size() > base) ? evq[base] : 10'h3FF;
        chk("t5_noprefix", {22'd0, ev}, {22'd0, 10'h01C});
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t5_clr", {31'd0, err}, 32'd0);
        err_clr      = 1'b1;
        kbd_overflow = 1'b1;
        cyc(1);
        err_clr      = 1'b0;
        kbd_overflow = 1'b0;
        chk("t5_set_wins", {31'd0, err}, 32'd1);
        cyc(2);
        chk("t5_sticky", {31'd0, err}, 32'd1);

        // Reset in the middle of EMIT
        base      = evq.size();
        evt_ready = 1'b0;
        push(8'h3B);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1);
            if (evt_valid) seen = 1'b1;
        end
        chk("t6_in_emit", {31'd0, seen}, 32'd1);
        #2 clrn = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, evt_valid},      32'd0);
        chk("t6_rst_code",  {24'd0, evt_code},       32'd0);
        chk("t6_rst_err",   {31'd0, err},            32'd0);
        chk("t6_rst_pop_n", {31'd0, kbd_nextdata_n}, 32'd1);
        evt_ready = 1'b1;
        cyc(2);
        clrn     = 1'b1;
        pop_mark = src_rd;
        cyc(10);
        chk("t6_no_pop", {25'd0, src_rd}, {25'd0, pop_mark});
        chk("t6_no_evt", evq.size() - base, 32'd0);
        // Held-key memory must be cleared by reset, so 3B is a fresh make
        push(8'h3B);
        cyc(10);
        ev = (evq.size() > base) ? evq[base] : 10'h3FF;
        chk("t6_held_rst", {22'd0, ev}, {22'd0, 10'h03B});
        chk("bad_pops", bad_pops, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
